ysyx_24110015_sram_responder: RTL and testbench
===============================================

// Module: ysyx_24110015_sram_responder
// PURPOSE
//  Memory-side responder for the core's fetch and load/store requests. It serves
//  an IFU read port and an LSU read/write port from one single-ported word array.
//  Fixed-priority arbitration (LSU over IFU) picks the winner; a latency counter
//  delays each response. Each port has a valid/ready request and response handshake.
//  Sits between the multicycle core (IFU/LSU) and the SoC memory map.
// PARAMETERS
//  DEPTH_LOG2  10            log2 of array depth in 32-bit words
//  BASE_ADDR   32'h8000_0000 byte address of word 0
//  LATENCY     2             cycles from request accept to rsp_valid (legal 1..15)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  if_req_valid in   1   IFU read request
//  if_req_ready out  1   IFU request accepted this cycle
//  if_req_addr  in   32  IFU byte address
//  if_rsp_valid out  1   IFU response valid
//  if_rsp_ready in   1   IFU takes response
//  if_rsp_rdata out  32  instruction word
//  if_rsp_err   out  1   address out of range or misaligned
//  ls_req_valid in   1   LSU request
//  ls_req_ready out  1   LSU request accepted this cycle
//  ls_req_wen   in   1   1 = write, 0 = read
//  ls_req_addr  in   32  LSU byte address
//  ls_req_wdata in   32  write data, lane-aligned
//  ls_req_wmask in   4   byte-enable mask for writes
//  ls_rsp_valid out  1   LSU response valid (read data or write acknowledge)
//  ls_rsp_ready in   1   LSU takes response
//  ls_rsp_rdata out  32  read data; 0 on writes
//  ls_rsp_err   out  1   address out of range or misaligned
// BEHAVIOUR
//  - Reset values: state=IDLE; all *_ready, *_rsp_valid and *_err are 0; rdata is 0;
//    the latency counter is 0. The array contents are not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE; one transaction is outstanding at a time.
//  - IDLE: ls_req_ready = ls_req_valid. if_req_ready = if_req_valid & ~ls_req_valid.
//    These are combinational grants and are 0 outside IDLE. The accepted port,
//    address, wen, wdata and wmask are registered. Counter loads LATENCY-1.
//    The next state is WAIT when LATENCY>1, otherwise RESP.
//  - WAIT: the counter decrements each cycle. At 1 it goes to RESP.
//  - Array access happens on the cycle that enters RESP.
//    Reads register the word into rdata.
//    Writes update only the bytes whose wmask bit is set.
//  - RESP: assert the winner's rsp_valid. Hold rdata and err stable until rsp_ready.
//    On the handshake cycle go to IDLE; a new request is accepted next cycle at the
//    earliest. Minimum spacing between accepts is LATENCY+1 cycles.
//  - Address check: index = (addr - BASE_ADDR) >> 2.
//    err = 1 if addr < BASE_ADDR, addr >= BASE_ADDR + 4*2^DEPTH_LOG2, or addr[1:0] != 0.
//    On err, the array is untouched and rdata = 0, but the response is still returned.
//  - Simultaneous requests in IDLE: the LSU wins. The IFU must keep valid asserted
//    and is granted after the LSU response completes. No starvation guarantee.
//  - A requester must hold valid and payload stable until ready. Dropping valid
//    before ready is legal and ignored.
//  - Asserting rst at any point aborts the transaction and returns to IDLE.
//    An uncommitted write (not yet in RESP) never reaches the array.
// STRUCTURE
//  - Shared package/header ysyx_24110015_mem_defs: state encodings
//    (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the port-id constants PORT_IF/PORT_LS.
//  - One sub-module, ysyx_24110015_sram_array: synchronous 32-bit word array with
//    per-byte write enables and a registered read port.
//  - The FSM, arbiter, counter and address check live in this top module.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles, then release.
//     -> all ready/valid/err are 0, and both ports see ready only while IDLE.
//  2. LSU write then read, LATENCY=2: write addr 0x8000_0010, data 0xDEADBEEF,
//     mask 4'b1111; then read the same address.
//     -> ls_rsp_valid 2 cycles after each accept; rdata=0xDEADBEEF, err=0.
//  3. Byte mask: write 0x11223344 with mask 4'b0101 over 0xDEADBEEF at 0x8000_0010, then read.
//     -> 0xDE22BE44.
//  4. Contention: if_req_valid and ls_req_valid asserted together, LSU read of 0x8000_0000.
//     -> ls_req_ready=1 and if_req_ready=0 that cycle; the IFU is granted the cycle
//        after the LSU response handshake.
//  5. Errors: IFU read 0x7FFF_FFFC, LSU write 0x8000_0002, and a read at
//     BASE+4*2^DEPTH_LOG2.
//     -> err=1 and rdata=0 each time; a read-back of the nearby valid words is unchanged.
//  6. Back-pressure and reset: hold ls_rsp_ready=0 for 5 cycles.
//     -> rsp_valid and rdata stable throughout.
//     Then pull rst low during WAIT of a pending write.
//     -> outputs clear at once, and a read-back shows the old data.

Source files
------------

// File: rtl/ysyx_24110015_mem_defs.sv
// Shared definitions for the SRAM responder:
// FSM encodings, port ids and the request bundle.
package ysyx_24110015_mem_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  typedef struct packed {
    logic        port;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_24110015_sram_array.sv
// Single-ported 32-bit word array with byte
// write enables and a registered read port.
module ysyx_24110015_sram_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) begin
            mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_24110015_sram_responder.sv
// IFU/LSU memory responder: LSU-priority arbiter,
// latency counter and one outstanding access.
module ysyx_24110015_sram_responder
  import ysyx_24110015_mem_defs::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_rdata,
  output logic        if_rsp_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_wen,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  input  logic [3:0]  ls_req_wmask,
  output logic        ls_rsp_valid,
  input  logic        ls_rsp_ready,
  output logic [31:0] ls_rsp_rdata,
  output logic        ls_rsp_err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  mem_req_t    in_req, cur;
  logic [31:0] off;
  logic        cur_err;
  logic        access;
  logic        resp, is_ls, hs;
  logic [31:0] arr_rdata, rd;

  always_comb begin
    in_req = '0;
    if (ls_req_valid) begin
      in_req.port  = PORT_LS;
      in_req.wen   = ls_req_wen;
      in_req.addr  = ls_req_addr;
      in_req.wdata = ls_req_wdata;
      in_req.wmask = ls_req_wmask;
    end else begin
      in_req.port  = PORT_IF;
      in_req.addr  = if_req_addr;
    end
  end

  // With LATENCY==1 the access happens in the accept
  // cycle, so the live request feeds the array there.
  assign cur = (state_q == IDLE) ? in_req : req_q;
  assign off = cur.addr - BASE_ADDR;
  assign cur_err = (cur.addr < BASE_ADDR)
                 | (|off[31:DEPTH_LOG2+2])
                 | (|off[1:0]);

  assign resp  = (state_q == RESP);
  assign is_ls = (req_q.port == PORT_LS);
  assign hs    = is_ls ? ls_rsp_ready : if_rsp_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    access       = 1'b0;
    ls_req_ready = 1'b0;
    if_req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        ls_req_ready = ls_req_valid;
        if_req_ready = if_req_valid & ~ls_req_valid;
        if (ls_req_valid | if_req_valid) begin
          req_d = in_req;
          cnt_d = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            access  = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  ysyx_24110015_sram_array #(
    .AW(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (access & ~cur_err),
    .we   (cur.wen),
    .idx  (off[DEPTH_LOG2+1:2]),
    .wdata(cur.wdata),
    .wmask(cur.wmask),
    .rdata(arr_rdata)
  );

  assign rd = (cur_err | req_q.wen) ? 32'h0 : arr_rdata;

  assign ls_rsp_valid = resp & is_ls;
  assign ls_rsp_err   = resp & is_ls & cur_err;
  assign ls_rsp_rdata = (resp & is_ls) ? rd : 32'h0;
  assign if_rsp_valid = resp & ~is_ls;
  assign if_rsp_err   = resp & ~is_ls & cur_err;
  assign if_rsp_rdata = (resp & ~is_ls) ? rd : 32'h0;

endmodule

// File: tb/tb_ysyx_24110015_sram_responder.sv
// Scoreboard bench for the SRAM responder:
// expected responses queued at accept, checked at handshake.
module tb_ysyx_24110015_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DL2  = 10;
  localparam int          LAT  = 2;

  logic        clk = 0;
  logic        rst = 0;
  logic        if_req_valid = 0;
  logic        if_req_ready;
  logic [31:0] if_req_addr = 0;
  logic        if_rsp_valid;
  logic        if_rsp_ready = 1;
  logic [31:0] if_rsp_rdata;
  logic        if_rsp_err;
  logic        ls_req_valid = 0;
  logic        ls_req_ready;
  logic        ls_req_wen = 0;
  logic [31:0] ls_req_addr = 0;
  logic [31:0] ls_req_wdata = 0;
  logic [3:0]  ls_req_wmask = 0;
  logic        ls_rsp_valid;
  logic        ls_rsp_ready = 1;
  logic [31:0] ls_rsp_rdata;
  logic        ls_rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] ls_q[$];
  logic [32:0] if_q[$];
  logic [31:0] mem_m [int];

  always #5 clk = ~clk;

  ysyx_24110015_sram_responder #(
    .DEPTH_LOG2(DL2),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr (if_req_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_ready(if_rsp_ready),
    .if_rsp_rdata(if_rsp_rdata),
    .if_rsp_err  (if_rsp_err),
    .ls_req_valid(ls_req_valid),
    .ls_req_ready(ls_req_ready),
    .ls_req_wen  (ls_req_wen),
    .ls_req_addr (ls_req_addr),
    .ls_req_wdata(ls_req_wdata),
    .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_ready(ls_rsp_ready),
    .ls_rsp_rdata(ls_rsp_rdata),
    .ls_rsp_err  (ls_rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", tag);
  endtask

  function automatic bit a_err(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'(4 << DL2))
        || (a[1:0] != 2'b00);
  endfunction

  function automatic int a_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [32:0] model(
      input logic wen, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] w;
    if (a_err(a)) return {1'b1, 32'h0};
    if (!wen) return {1'b0, mem_m[a_idx(a)]};
    w = mem_m.exists(a_idx(a)) ? mem_m[a_idx(a)] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem_m[a_idx(a)] = w;
    return {1'b0, 32'h0};
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst && ls_rsp_valid && ls_rsp_ready) begin
      if (ls_q.size() == 0) timeout("ls_unexpected_rsp");
      else begin
        e = ls_q.pop_front();
        chk("ls_rdata", 64'(ls_rsp_rdata), 64'(e[31:0]));
        chk("ls_err", 64'(ls_rsp_err), 64'(e[32]));
      end
    end
    if (rst && if_rsp_valid && if_rsp_ready) begin
      if (if_q.size() == 0) timeout("if_unexpected_rsp");
      else begin
        e = if_q.pop_front();
        chk("if_rdata", 64'(if_rsp_rdata), 64'(e[31:0]));
        chk("if_err", 64'(if_rsp_err), 64'(e[32]));
      end
    end
  end

  task automatic ls_issue(input logic wen,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [3:0] m,
                          input bit commit);
    bit ok = 0;
    ls_req_valid = 1;
    ls_req_wen   = wen;
    ls_req_addr  = a;
    ls_req_wdata = wd;
    ls_req_wmask = m;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = ls_req_ready;
    end
    if (!ok) timeout("ls_req_ready");
    else if (commit) ls_q.push_back(model(wen, a, wd, m));
    @(posedge clk);
    #1 ls_req_valid = 0;
  endtask

  task automatic if_issue(input logic [31:0] a);
    bit ok = 0;
    if_req_valid = 1;
    if_req_addr  = a;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = if_req_ready;
    end
    if (!ok) timeout("if_req_ready");
    else if_q.push_back(model(1'b0, a, 32'h0, 4'h0));
    @(posedge clk);
    #1 if_req_valid = 0;
  endtask

  task automatic wait_rsp(input bit ls);
    int  lat = 0;
    bit  ok  = 0;
    while (!ok && lat < 50) begin
      @(negedge clk);
      lat++;
      ok = ls ? ls_rsp_valid : if_rsp_valid;
    end
    if (!ok) timeout(ls ? "ls_rsp_valid" : "if_rsp_valid");
    else chk(ls ? "ls_latency" : "if_latency", 64'(lat), 64'(LAT));
    @(posedge clk);
    #1;
  endtask

  task automatic ls_txn(input logic wen, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
    ls_issue(wen, a, wd, m, 1'b1);
    wait_rsp(1'b1);
  endtask

  initial begin
    int k;
    logic [31:0] hold;
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ls_ready", 64'(ls_req_ready), 0);
    chk("rst_if_ready", 64'(if_req_ready), 0);
    chk("rst_ls_valid", 64'(ls_rsp_valid), 0);
    chk("rst_if_valid", 64'(if_rsp_valid), 0);
    chk("rst_errs", 64'({ls_rsp_err, if_rsp_err}), 0);
    chk("rst_rdata", 64'(ls_rsp_rdata | if_rsp_rdata), 0);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    // write/read and byte mask
    ls_txn(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111);
    ls_txn(0, BASE + 32'h10, 32'h0, 4'h0);
    ls_txn(1, BASE + 32'h10, 32'h1122_3344, 4'b0101);
    ls_txn(0, BASE + 32'h10, 32'h0, 4'h0);
    chk("mask_model", 64'(mem_m[4]), 64'h0000_0000_DE22_BE44);
    ls_txn(1, BASE, 32'hA5A5_0F0F, 4'b1111);
    ls_txn(1, BASE + 32'hFFC, 32'h1234_5678, 4'b1111);
    if_issue(BASE + 32'hFFC);
    wait_rsp(1'b0);
    // contention
    if_req_valid = 1;
    if_req_addr  = BASE + 32'h10;
    ls_req_valid = 1;
    ls_req_wen   = 0;
    ls_req_addr  = BASE;
    @(negedge clk);
    chk("arb_ls_ready", 64'(ls_req_ready), 1);
    chk("arb_if_ready", 64'(if_req_ready), 0);
    ls_q.push_back(model(1'b0, BASE, 32'h0, 4'h0));
    @(posedge clk);
    #1 ls_req_valid = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      chk("if_ready_busy", 64'(if_req_ready), 0);
    end while (!ls_rsp_valid && k < 20);
    if (!ls_rsp_valid) timeout("arb_ls_rsp");
    @(negedge clk);
    chk("if_grant_after", 64'(if_req_ready), 1);
    if_q.push_back(model(1'b0, BASE + 32'h10, 32'h0, 4'h0));
    @(posedge clk);
    #1 if_req_valid = 0;
    wait_rsp(1'b0);
    // error responses
    if_issue(32'h7FFF_FFFC);
    wait_rsp(1'b0);
    ls_txn(1, BASE + 32'h2, 32'hFFFF_FFFF, 4'b1111);
    ls_txn(0, BASE + 32'(4 << DL2), 32'h0, 4'h0);
    ls_txn(1, BASE + 32'(4 << DL2), 32'h0BAD_0BAD, 4'hF);
    ls_txn(0, BASE, 32'h0, 4'h0);
    ls_txn(0, BASE + 32'hFFC, 32'h0, 4'h0);
    // back-pressure
    ls_rsp_ready = 0;
    ls_issue(0, BASE + 32'h10, 32'h0, 4'h0, 1'b1);
    hold = mem_m[4];
    k = 0;
    while (!ls_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ls_rsp_valid) timeout("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(ls_rsp_valid), 1);
      chk("bp_rdata", 64'(ls_rsp_rdata), 64'(hold));
      @(negedge clk);
    end
    ls_rsp_ready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    // reset during WAIT of a pending write
    ls_issue(1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0);
    rst = 0;
    #1;
    chk("ab_ls_valid", 64'(ls_rsp_valid), 0);
    chk("ab_ls_ready", 64'(ls_req_ready), 0);
    chk("ab_ls_rdata", 64'(ls_rsp_rdata), 0);
    chk("ab_ls_err", 64'(ls_rsp_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    ls_txn(0, BASE + 32'h10, 32'h0, 4'h0);
    chk("ls_q_empty", 64'(ls_q.size()), 0);
    chk("if_q_empty", 64'(if_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
